// File: rtl/ram_dp_hex.sv
// Simple dual-port RAM: registered read, hardware clear sequencer, per-nibble 7-seg readout.
// Define RAM_WR_BYPASS_EN for write-first same-address behaviour (default read-first).

module ram_dp_hex_seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7f;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      4'hf: seg = 7'h0e;
      default: seg = 7'h7f;
    endcase
  end
endmodule

module ram_dp_hex #(
  parameter int DW   = 8,
  parameter int AW   = 4,
  parameter int NHEX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     inaddr,
  input  logic [AW-1:0]     outaddr,
  input  logic [DW-1:0]     din,
  input  logic              clr,
  output logic [DW-1:0]     dout,
  output logic              busy,
  output logic [7*NHEX-1:0] HEX
);
  localparam int PW = (DW > 4*NHEX) ? DW : 4*NHEX;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] mem_q [2**AW];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [PW-1:0] dout_pad;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = inaddr;
    mem_wdata = din;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + AW'(1);
        dout_d    = '0;
        if (ptr_q == '1) state_d = RUN;
      end
      RUN: begin
        dout_d = mem_q[outaddr];
        if (clr) begin
          // a write in the clr cycle is dropped; the sweep starts next edge
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (we) begin
          mem_we = 1'b1;
`ifdef RAM_WR_BYPASS_EN
          if (inaddr == outaddr) dout_d = din;
`endif
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
    end
  end

  // array has no reset; the clear sweep after reset zeros it
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign dout = dout_q;
  assign busy = (state_q == CLEAR);

  always_comb begin
    dout_pad         = '0;
    dout_pad[DW-1:0] = dout_q;
  end

  for (genvar i = 0; i < NHEX; i++) begin : g_dig
    ram_dp_hex_seg u_seg (
      .nib(dout_pad[4*i +: 4]),
      .seg(HEX[7*i +: 7])
    );
  end
endmodule
